// File: rtl/risc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : risc_control_fsm
//  Description : Multi-cycle control sequencer for the 8-bit RISC core.
//                Steps each instruction through FETCH, DECODE and one of
//                EXEC / MEM / BRANCH, and parks in HALT on HLT.  Drives the
//                PC increment strobe, IR load, ALU op select, register-file
//                write enable and a request/ready memory handshake.
//  Ports       : clk_i          system clock (rising edge)
//                rst_ni         asynchronous active-low reset
//                opcode_i       IR opcode, stable from DECODE onward
//                zero_i         ALU zero flag, used in BRANCH
//                mem_ready_i    memory completion, qualifies mem_req_o
//                mem_req_o      memory access request
//                mem_we_o       1 = write (ST), 0 = read
//                addr_sel_o     0 = PC address, 1 = data address
//                loadir_o       IR load strobe
//                loadpc_o       PC increment strobe
//                branch_take_o  PC mux selects branch target
//                alu_op_o       0 pass, 1 add, 2 sub, 3 and, 4 or
//                reg_we_o       register-file write strobe
//                halted_o       high in HALT
//                illegal_o      sticky illegal-opcode flag
//                state_o        current state code (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module risc_control_fsm #(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [OPW-1:0]  opcode_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            addr_sel_o,
  output logic            loadir_o,
  output logic            loadpc_o,
  output logic            branch_take_o,
  output logic [ALUW-1:0] alu_op_o,
  output logic            reg_we_o,
  output logic            halted_o,
  output logic            illegal_o,
  output logic [2:0]      state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_BRANCH = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(3);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4);
  localparam logic [OPW-1:0] OP_LD   = OPW'(5);
  localparam logic [OPW-1:0] OP_ST   = OPW'(6);
  localparam logic [OPW-1:0] OP_BEQZ = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT  = OPW'(15);

  localparam logic [ALUW-1:0] ALU_PASS = ALUW'(0);
  localparam logic [ALUW-1:0] ALU_ADD  = ALUW'(1);
  localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_AND  = ALUW'(3);
  localparam logic [ALUW-1:0] ALU_OR   = ALUW'(4);

  logic [2:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode_i)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC;
          OP_LD, OP_ST:                  state_d = S_MEM;
          OP_BEQZ, OP_JMP:               state_d = S_BRANCH;
          OP_HLT:                        state_d = S_HALT;
          OP_NOP:                        state_d = S_FETCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC:   state_d = S_FETCH;
      S_MEM: begin
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      // Unused codes fall back to a clean fetch.
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  logic            in_fetch, in_exec, in_mem, in_branch, in_halt;
  logic            mem_req, mem_we, addr_sel, load_strobe, branch_take, reg_we;
  logic [ALUW-1:0] alu_op;

  assign in_fetch  = (state_q == S_FETCH);
  assign in_exec   = (state_q == S_EXEC);
  assign in_mem    = (state_q == S_MEM);
  assign in_branch = (state_q == S_BRANCH);
  assign in_halt   = (state_q == S_HALT);

  assign mem_req     = in_fetch | in_mem;
  assign mem_we      = in_mem & (opcode_i == OP_ST);
  assign addr_sel    = in_mem;
  // IR load and PC increment share the cycle that completes the fetch.
  assign load_strobe = in_fetch & mem_ready_i;
  assign branch_take = in_branch &
                       ((opcode_i == OP_JMP) | ((opcode_i == OP_BEQZ) & zero_i));
  assign reg_we      = in_exec | (in_mem & (opcode_i == OP_LD) & mem_ready_i);

  always_comb begin
    alu_op = ALU_PASS;
    if (in_exec) begin
      case (opcode_i)
        OP_ADD:  alu_op = ALU_ADD;
        OP_SUB:  alu_op = ALU_SUB;
        OP_AND:  alu_op = ALU_AND;
        OP_OR:   alu_op = ALU_OR;
        default: alu_op = ALU_PASS;
      endcase
    end
  end

  // State resets to FETCH, whose decode asserts mem_req; gating with the
  // reset input keeps every output at its reset value while reset is held,
  // and the first request appears as soon as reset is released.
  assign mem_req_o     = rst_ni & mem_req;
  assign mem_we_o      = rst_ni & mem_we;
  assign addr_sel_o    = rst_ni & addr_sel;
  assign loadir_o      = rst_ni & load_strobe;
  assign loadpc_o      = rst_ni & load_strobe;
  assign branch_take_o = rst_ni & branch_take;
  assign alu_op_o      = rst_ni ? alu_op : ALU_PASS;
  assign reg_we_o      = rst_ni & reg_we;
  assign halted_o      = rst_ni & in_halt;
  assign illegal_o     = illegal_q;
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc_control_fsm
//  Description : Self-checking bench for risc_control_fsm.  A per-cycle
//                reference model predicts state and every output; a table of
//                instructions checks latency and strobe counts; hand-written
//                sequences cover async reset mid-access and HALT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_risc_control_fsm;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, addr_sel_o, loadir_o, loadpc_o;
  logic       branch_take_o, reg_we_o, halted_o, illegal_o;
  logic [2:0] alu_op_o;
  logic [2:0] state_o;

  risc_control_fsm #(.OPW(4), .ALUW(3)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .opcode_i      (opcode_i),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .addr_sel_o    (addr_sel_o),
    .loadir_o      (loadir_o),
    .loadpc_o      (loadpc_o),
    .branch_take_o (branch_take_o),
    .alu_op_o      (alu_op_o),
    .reg_we_o      (reg_we_o),
    .halted_o      (halted_o),
    .illegal_o     (illegal_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase of the current instruction and sticky illegal flag.
  // Phase numbers are the published debug state codes.
  int m_phase = 0;
  bit m_ill   = 0;

  // Per-instruction strobe statistics gathered from the DUT.
  int st_lpc, st_rw, st_bt, st_mwe, st_cyc;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] pack_dut();
    return {state_o, mem_req_o, mem_we_o, addr_sel_o, loadir_o, loadpc_o,
            branch_take_o, alu_op_o, reg_we_o, halted_o, illegal_o};
  endfunction

  // Expected outputs from the instruction's phase and the current inputs.
  function automatic logic [15:0] model_out(int ph, int op, bit z, bit rdy, bit ill);
    bit fetch, dec, exe, mem, br, hlt;
    bit req, we, asel, ld, bt, rw;
    int alu;
    fetch = (ph == 0); dec = (ph == 1); exe = (ph == 2);
    mem = (ph == 3); br = (ph == 4); hlt = (ph == 5);
    req  = fetch || mem;
    we   = mem && (op == 6);
    asel = mem;
    ld   = fetch && rdy;
    bt   = br && (op == 8 || (op == 7 && z));
    alu  = exe ? op : 0;        // ADD..OR are opcodes 1..4, alu codes 1..4
    rw   = exe || (mem && op == 5 && rdy);
    if (dec) begin req = 0; end
    return {ph[2:0], req, we, asel, ld, ld, bt, alu[2:0], rw, hlt, ill};
  endfunction

  function automatic int model_next(int ph, int op, bit rdy);
    case (ph)
      0: return rdy ? 1 : 0;
      1: begin
        if (op >= 1 && op <= 4) return 2;
        if (op == 5 || op == 6) return 3;
        if (op == 7 || op == 8) return 4;
        if (op == 15)           return 5;
        return 0;
      end
      3: return rdy ? 0 : 3;
      5: return 5;
      default: return 0;
    endcase
  endfunction

  // One clock: entered just after a rising edge, drives inputs, compares
  // everything at the falling edge, then advances the model.
  task automatic tick(input int op, input bit z, input bit rdy);
    logic [15:0] exp, act;
    int nxt;
    opcode_i    = op[3:0];
    zero_i      = z;
    mem_ready_i = rdy;
    @(negedge clk_i);
    exp = model_out(m_phase, op, z, rdy, m_ill);
    act = pack_dut();
    chk("cycle_outputs", int'(act), int'(exp));
    st_cyc++;
    st_lpc += int'(loadpc_o);
    st_rw  += int'(reg_we_o);
    st_bt  += int'(branch_take_o);
    st_mwe += int'(mem_we_o);
    nxt = model_next(m_phase, op, rdy);
    if (m_phase == 1 && op >= 9 && op <= 14) m_ill = 1;
    @(posedge clk_i);
    #1;
    m_phase = nxt;
  endtask

  // Runs one instruction from FETCH back to FETCH with `waits` not-ready
  // cycles in FETCH and in MEM.
  task automatic run_instr(input int op, input bit z, input int waits);
    int mw;
    int guard;
    st_lpc = 0; st_rw = 0; st_bt = 0; st_mwe = 0; st_cyc = 0;
    for (int w = 0; w < waits; w++) tick(op, z, 1'b0);
    tick(op, z, 1'b1);
    mw = 0;
    guard = 0;
    while (m_phase != 0 && guard < 50) begin
      if (m_phase == 3 && mw < waits) begin
        mw++;
        tick(op, z, 1'b0);
      end else begin
        tick(op, z, 1'b1);
      end
      guard++;
    end
    if (guard >= 50) chk("instr_timeout", guard, 0);
  endtask

  typedef struct {
    int op;
    bit z;
    int waits;
    int cyc;
    int lpc;
    int rw;
    int bt;
    int mwe;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int hs;
    rst_ni = 1'b0; opcode_i = 4'd0; zero_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    chk("reset_outputs_t0", int'(pack_dut()), 0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs_held", int'(pack_dut()), 0);
    rst_ni = 1'b1;
    m_phase = 0; m_ill = 0;
    #1;
    chk("first_req_after_reset", int'(mem_req_o), 1);

    //          op z waits cyc lpc rw bt mwe
    vecs.push_back('{1, 0, 0, 3, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 3, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 4, 7, 1, 1, 0, 0});
    vecs.push_back('{2, 1, 1, 4, 1, 1, 0, 0});
    vecs.push_back('{3, 0, 0, 3, 1, 1, 0, 0});
    vecs.push_back('{4, 0, 2, 5, 1, 1, 0, 0});
    vecs.push_back('{6, 0, 2, 7, 1, 0, 0, 3});
    vecs.push_back('{5, 0, 2, 7, 1, 1, 0, 0});
    vecs.push_back('{5, 1, 0, 3, 1, 1, 0, 0});
    vecs.push_back('{7, 1, 0, 3, 1, 0, 1, 0});
    vecs.push_back('{7, 0, 0, 3, 1, 0, 0, 0});
    vecs.push_back('{8, 0, 1, 4, 1, 0, 1, 0});
    vecs.push_back('{8, 1, 0, 3, 1, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 2, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 3, 5, 1, 0, 0, 0});
    vecs.push_back('{11, 0, 0, 2, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 3, 1, 1, 0, 0});

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].z, vecs[i].waits);
      chk($sformatf("v%0d_cycles", i), st_cyc, vecs[i].cyc);
      chk($sformatf("v%0d_loadpc", i), st_lpc, vecs[i].lpc);
      chk($sformatf("v%0d_reg_we", i), st_rw,  vecs[i].rw);
      chk($sformatf("v%0d_branch", i), st_bt,  vecs[i].bt);
      chk($sformatf("v%0d_mem_we", i), st_mwe, vecs[i].mwe);
    end
    chk("illegal_sticky", int'(illegal_o), 1);

    // Randomized instruction stream; opcode only changes while fetching.
    begin
      int cur;
      cur = 1;
      for (int n = 0; n < 600; n++) begin
        if (m_phase == 0) cur = $urandom_range(0, 14);
        tick(cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      end
      hs = 0;
      while (m_phase != 0 && hs < 20) begin
        tick(cur, 1'b0, 1'b1);
        hs++;
      end
    end

    // Reset pulled low during a MEM wait.
    tick(5, 0, 1);
    tick(5, 0, 0);
    tick(5, 0, 0);
    chk("mem_wait_req", int'({mem_req_o, addr_sel_o, state_o}), 'b1_1_011);
    rst_ni = 1'b0;
    #1;
    chk("async_reset_outputs", int'(pack_dut()), 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    m_phase = 0; m_ill = 0;
    #1;
    chk("post_reset_req", int'({state_o, mem_req_o, addr_sel_o}), 'b000_1_0);
    tick(1, 0, 0);
    run_instr(1, 0, 0);

    // HLT: parks in HALT with no strobes until reset.
    tick(15, 0, 1);
    tick(15, 0, 0);
    st_lpc = 0; st_rw = 0; st_bt = 0; st_mwe = 0; st_cyc = 0;
    hs = 0;
    for (int n = 0; n < 20; n++) begin
      tick($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      a = pack_dut();
      hs += int'(mem_req_o) + int'(loadir_o) + int'(reg_we_o) + int'(branch_take_o);
    end
    chk("halt_state", int'(state_o), 5);
    chk("halt_flag", int'(halted_o), 1);
    chk("halt_no_strobes", hs + st_lpc + st_rw + st_bt + st_mwe, 0);
    rst_ni = 1'b0;
    #1;
    chk("halt_reset", int'(pack_dut()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_control_fsm.md
# risc_control_fsm

Multi-cycle sequencer for the 8-bit RISC core. It drives the program counter increment strobe, the instruction-register load, the ALU operation select, the register-file write enable and a request/ready memory handshake. It steps each instruction through fetch, decode, execute/memory/branch, and halts on HLT. It sits between the instruction register (opcode, ALU zero flag) and the datapath control inputs.

## Interface
- OPW, 4, opcode width
- ALUW, 3, alu_op width
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; low forces state and all registered outputs to reset values immediately
- opcode  input  OPW  current instruction-register opcode, stable from the DECODE cycle onward
- zero  input  1  ALU zero flag, sampled in BRANCH
- mem_ready  input  1  memory completion; meaningful only while mem_req=1
- mem_req  output  1  memory access request, held until mem_ready
- mem_we  output  1  1=write (ST), 0=read; valid while mem_req=1
- addr_sel  output  1  0=PC drives address, 1=data address drives address
- loadir  output  1  instruction-register load strobe
- loadpc  output  1  PC increment strobe, single-cycle pulse
- branch_take  output  1  PC mux selects branch target this cycle
- alu_op  output  ALUW  0=pass,1=add,2=sub,3=and,4=or
- reg_we  output  1  register-file write strobe
- halted  output  1  high in HALT
- illegal  output  1  sticky; set on decode of an unassigned opcode, cleared only by reset
- state  output  3  current state encoding, for debug

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LD, 6 ST, 7 BEQZ, 8 JMP, 15 HLT; 9–14 are illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, BRANCH=4, HALT=5. Codes 6–7 are unreachable and recover to FETCH on the next clock.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - While mem_ready=0, stay in FETCH.
  - When mem_ready=1, pulse loadir=1 and loadpc=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no strobes. Next state by opcode:
  - 1–4 → EXEC
  - 5–6 → MEM
  - 7–8 → BRANCH
  - 15 → HALT
  - 0 → FETCH
  - 9–14 → FETCH, and set illegal.
- EXEC: alu_op = opcode[2:0] mapping (ADD=1, SUB=2, AND=3, OR=4); reg_we=1 for one cycle; then FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for ST and 0 for LD.
  - Wait for mem_ready.
  - On mem_ready=1: reg_we=1 that cycle for LD only, then FETCH.
- BRANCH:
  - branch_take=1 when opcode=8, or when opcode=7 and zero=1.
  - Otherwise branch_take=0.
  - Always go to FETCH next.
- HALT: halted=1, all strobes 0, mem_req=0. Only reset leaves HALT.
- Outputs that default outside their active state: alu_op=0, addr_sel=0, mem_we=0.

## Timing
- Reset values:
  - state=FETCH (0)
  - all strobes 0: mem_req, mem_we, addr_sel, loadir, loadpc, branch_take, reg_we
  - alu_op=0, halted=0, illegal=0
- First mem_req=1 appears in the first cycle after reset deasserts.
- Decoding of outputs:
  - mem_req, addr_sel, mem_we, alu_op, branch_take and halted are Moore outputs, decoded from state and opcode.
  - loadir, loadpc, and reg_we in MEM are qualified combinationally by mem_ready in the same cycle.
- Latency with mem_ready tied high:
  - ALU instruction: 3 cycles (FETCH, DECODE, EXEC)
  - LD/ST: 3 cycles
  - branch: 3 cycles
  - NOP/illegal: 2 cycles
  - Each wait cycle of mem_ready adds exactly 1 cycle.
- Handshake rules:
  - Once mem_req rises, it stays high, with addr_sel and mem_we stable, until the cycle in which mem_ready=1.
  - mem_req drops on the following clock.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready stuck low means the FSM waits indefinitely; there is no timeout.
- loadpc fires exactly once per fetched instruction. branch_take and loadpc are never high in the same cycle.
- Reset asserted mid-access: outputs go to reset values asynchronously, the pending access is abandoned, and the FSM restarts in FETCH.

## Test plan
- Reset release, mem_ready=1, opcode stream ADD(1): state sequence 0,1,2,0 repeating; loadpc pulses every 3rd cycle; reg_we high in state 2 with alu_op=1.
- FETCH with mem_ready low for 4 cycles, then high: mem_req high for 5 cycles with addr_sel=0; loadir/loadpc pulse only in the 5th cycle; state moves to 1 on the next clock.
- ST(6) then LD(5) with 2 wait cycles each: mem_we=1/addr_sel=1 held for 3 cycles for ST, with no reg_we; LD asserts reg_we only in its ready cycle.
- BEQZ(7): with zero=1, branch_take=1 in BRANCH; with zero=0, branch_take=0. JMP(8) gives branch_take=1 regardless of zero.
- Opcode 11 gives illegal=1 and next state FETCH; illegal stays 1 after a following ADD. HLT(15) gives halted=1 and state=5 held for 20 cycles with no strobes.
- Reset pulled low during MEM wait (mem_req=1): all outputs are 0 in the same cycle without a clock; after release, state=0 and mem_req=1 with addr_sel=0.
